// File: rtl/pipe_stage_latch_pkg.sv
// Shared constants for the generic pipeline latch: NOP encoding and field map.
package pipe_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int FLD_O  = 0;
    localparam int FLD_D  = 1;
    localparam int FLD_IR = 2;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NFIELDS = 3;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2
    } latch_act_e;

    // Flush outranks stall, stall outranks load.
    function automatic latch_act_e latch_act(
        input logic stall,
        input logic flush
    );
        latch_act_e a;
        if (flush)      a = ACT_FLUSH;
        else if (stall) a = ACT_STALL;
        else            a = ACT_LOAD;
        return a;
    endfunction

endpackage

// File: rtl/pipe_stage_latch_if.sv
// Upstream/control/downstream bundle of one pipeline latch.
interface pipe_stage_latch_if
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NFIELDS = DEF_NFIELDS
);
    logic                      in_valid;
    logic [NFIELDS*DATA_W-1:0] in_bus;
    logic                      stall;
    logic                      flush;
    logic                      out_valid;
    logic [NFIELDS*DATA_W-1:0] out_bus;

    modport master (
        output in_valid,
        output in_bus,
        output stall,
        output flush,
        input  out_valid,
        input  out_bus
    );

    modport slave (
        input  in_valid,
        input  in_bus,
        input  stall,
        input  flush,
        output out_valid,
        output out_bus
    );
endinterface

// File: rtl/pipe_stage_latch_field_reg.sv
// One field word: async reset value, load enable, synchronous squash value.
module pipe_field_reg
    import pipe_pkg::*;
#(
    parameter int             W       = DEF_DATA_W,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter logic [W-1:0]   SQ_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         sq_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (sq_i)      q_d = SQ_VAL;
        else if (en_i) q_d = d_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= RST_VAL;
        else        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Generic inter-stage latch with stall/flush/bubble handling.
// Optional perf counters when PIPE_LATCH_PERF_EN is defined.
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                NFIELDS = DEF_NFIELDS,
    parameter int                IR_IDX  = NFIELDS - 1,
    parameter logic [DATA_W-1:0] NOP_IR  = DATA_W'(NOP)
`ifdef PIPE_LATCH_PERF_EN
    ,
    parameter int                CNT_W   = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    pipe_stage_latch_if.slave lat
`ifdef PIPE_LATCH_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    latch_act_e act;
    logic       valid_q;
    logic       valid_d;
    logic [DATA_W-1:0] fld_q [NFIELDS];

    assign act = latch_act(lat.stall, lat.flush);

    always_comb begin
        valid_d = valid_q;
        unique case (act)
            ACT_FLUSH: valid_d = 1'b0;
            ACT_STALL: valid_d = valid_q;
            ACT_LOAD:  valid_d = lat.in_valid;
            default:   valid_d = valid_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid_q <= 1'b0;
        else          valid_q <= valid_d;
    end

    for (genvar k = 0; k < NFIELDS; k++) begin : g_fld
        localparam logic [DATA_W-1:0] FILL =
            (k == IR_IDX) ? NOP_IR : '0;
        logic [DATA_W-1:0] d;

        // A bubble must never carry a real instruction word.
        assign d = ((k == IR_IDX) && !lat.in_valid)
                 ? NOP_IR
                 : lat.in_bus[k*DATA_W +: DATA_W];

        pipe_field_reg #(
            .W       (DATA_W),
            .RST_VAL (FILL),
            .SQ_VAL  (FILL)
        ) u_reg (
            .clk   (clk),
            .rst_n (reset_n),
            .en_i  (act == ACT_LOAD),
            .sq_i  (act == ACT_FLUSH),
            .d_i   (d),
            .q_o   (fld_q[k])
        );
    end

    always_comb begin
        lat.out_bus = '0;
        for (int k = 0; k < NFIELDS; k++) begin
            lat.out_bus[k*DATA_W +: DATA_W] = fld_q[k];
        end
    end

    assign lat.out_valid = valid_q;

`ifdef PIPE_LATCH_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             bubble_ld;

    assign bubble_ld = (act == ACT_LOAD) && !lat.in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (act == ACT_STALL && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (act == ACT_FLUSH && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (bubble_ld && bubble_cnt_q != CNT_MAX)
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Randomized bench for pipe_stage_latch against a field-level reference model.
module tb_pipe_stage_latch;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam int IR = NF - 1;
    localparam int CW = 4;
    localparam int BW = NF * DW;
    localparam logic [DW-1:0] NOPV = NOP;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    pipe_stage_latch_if #(.DATA_W(DW), .NFIELDS(NF)) bus_if ();

`ifdef PIPE_LATCH_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    pipe_stage_latch #(
        .DATA_W  (DW),
        .NFIELDS (NF),
        .IR_IDX  (IR),
        .NOP_IR  (NOPV)
`ifdef PIPE_LATCH_PERF_EN
        ,
        .CNT_W   (CW)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lat        (bus_if.slave)
`ifdef PIPE_LATCH_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic          mv;
    logic [DW-1:0] mf [NF];
    int            ms;
    int            mfl;
    int            mb;

    function automatic logic [BW-1:0] pack(
        input logic [DW-1:0] f2,
        input logic [DW-1:0] f1,
        input logic [DW-1:0] f0
    );
        return {f2, f1, f0};
    endfunction

    function automatic int sat(input int v);
        return (v < (2**CW - 1)) ? v + 1 : v;
    endfunction

    task automatic chk(
        input string          nm,
        input logic [BW-1:0]  act,
        input logic [BW-1:0]  exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset;
        mv = 1'b0;
        for (int k = 0; k < NF; k++) mf[k] = (k == IR) ? NOPV : '0;
        ms  = 0;
        mfl = 0;
        mb  = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, BW'(bus_if.out_valid), BW'(mv));
        for (int k = 0; k < NF; k++)
            chk($sformatf("%s.field%0d", tag, k),
                BW'(bus_if.out_bus[k*DW +: DW]), BW'(mf[k]));
        if (bus_if.out_valid !== 1'b1)
            chk({tag, ".bubble_ir"},
                BW'(bus_if.out_bus[IR*DW +: DW]), BW'(NOPV));
`ifdef PIPE_LATCH_PERF_EN
        chk({tag, ".stall_cnt"},  BW'(stall_cnt),  BW'(ms));
        chk({tag, ".flush_cnt"},  BW'(flush_cnt),  BW'(mfl));
        chk({tag, ".bubble_cnt"}, BW'(bubble_cnt), BW'(mb));
`endif
    endtask

    // Advance the model by one edge using the inputs now held, then compare.
    task automatic step(input string tag);
        if (bus_if.flush) begin
            mv = 1'b0;
            for (int k = 0; k < NF; k++) mf[k] = (k == IR) ? NOPV : '0;
            mfl = sat(mfl);
        end else if (bus_if.stall) begin
            ms = sat(ms);
        end else begin
            mv = bus_if.in_valid;
            for (int k = 0; k < NF; k++) mf[k] = bus_if.in_bus[k*DW +: DW];
            if (!bus_if.in_valid) begin
                mf[IR] = NOPV;
                mb = sat(mb);
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(
        input logic          v,
        input logic [BW-1:0] b,
        input logic          s,
        input logic          f
    );
        bus_if.in_valid = v;
        bus_if.in_bus   = b;
        bus_if.stall    = s;
        bus_if.flush    = f;
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        chk("reset.lit_bus", bus_if.out_bus, pack(NOPV, 0, 0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        drive(1'b1, pack(32'hA, 32'hB, 32'hC), 1'b0, 1'b0);
        step("load");
        chk("load.lit_bus", bus_if.out_bus, pack(32'hA, 32'hB, 32'hC));
        chk("load.lit_valid", BW'(bus_if.out_valid), BW'(1));

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pack($urandom, $urandom, $urandom), 1'b1, 1'b0);
            step("stall");
        end
        chk("stall.lit_bus", bus_if.out_bus, pack(32'hA, 32'hB, 32'hC));
`ifdef PIPE_LATCH_PERF_EN
        chk("stall.lit_cnt", BW'(stall_cnt), BW'(3));
`endif

        drive(1'b1, pack(32'h5, 32'h6, 32'h7), 1'b1, 1'b1);
        step("flush");
        chk("flush.lit_bus", bus_if.out_bus, pack(NOPV, 0, 0));
`ifdef PIPE_LATCH_PERF_EN
        chk("flush.lit_fcnt", BW'(flush_cnt), BW'(1));
        chk("flush.lit_scnt", BW'(stall_cnt), BW'(3));
`endif

        drive(1'b0, pack(32'hDEAD, 32'h2, 32'h1), 1'b0, 1'b0);
        step("bubble");
        chk("bubble.lit_bus", bus_if.out_bus, pack(NOPV, 32'h2, 32'h1));
`ifdef PIPE_LATCH_PERF_EN
        chk("bubble.lit_cnt", BW'(bubble_cnt), BW'(1));
`endif

        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom), pack($urandom, $urandom, $urandom),
                  1'b1, 1'b0);
            step("sat");
        end
`ifdef PIPE_LATCH_PERF_EN
        chk("sat.lit_cnt", BW'(stall_cnt), BW'(15));
`endif

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  pack($urandom, $urandom, $urandom),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0));
            #1;
            compare_all("nocomb");
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all("rand_reset");
                @(negedge clk);
                reset_n = 1'b1;
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
